// File: rtl/wave_ctrl_pkg.sv
// Shared types and sizing for the waveform RAM playback controller.
package wave_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_e;

    localparam int unsigned BUF_DEPTH = 2;
    // Wide enough to hold 0..BUF_DEPTH (stored samples plus the read in flight).
    localparam int unsigned CREDIT_W  = $clog2(BUF_DEPTH + 1);

endpackage

// File: rtl/wave_skid_fifo.sv
// Two-entry synchronous FIFO that catches RAM read data so the sample stream
// can stall without losing reads already in flight.
module wave_skid_fifo
    import wave_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [CREDIT_W-1:0]   o_count
);

    logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
    // Single-bit pointers: the depth is fixed at two entries.
    logic                  wr_ptr_q;
    logic                  rd_ptr_q;
    logic [CREDIT_W-1:0]   count_q;
    logic                  pop_ok;

    assign o_valid = (count_q != '0);
    assign o_data  = mem_q[rd_ptr_q];
    assign o_count = count_q;
    assign pop_ok  = i_pop && o_valid;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            if (i_push) begin
                mem_q[wr_ptr_q] <= i_data;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            unique case ({i_push, pop_ok})
                2'b10:   count_q <= count_q + CREDIT_W'(1);
                2'b01:   count_q <= count_q - CREDIT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/wave_ram_ctrl.sv
// Waveform RAM controller: loader writes in IDLE, windowed one-shot/loop
// playback into a valid/ready sample stream with full backpressure.
module wave_ram_ctrl
    import wave_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 11
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_stop,
    input  logic                  i_loop,
    input  logic [ADDR_WIDTH:0]   i_len,
    input  logic                  i_wr_valid,
    input  logic [ADDR_WIDTH-1:0] i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_wr_ready,
    output logic                  o_ram_wren,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_st_data,
    input  logic [DATA_WIDTH-1:0] i_ram_ld_data,
    output logic [DATA_WIDTH-1:0] o_smp_data,
    output logic                  o_smp_valid,
    input  logic                  i_smp_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    localparam logic [ADDR_WIDTH:0] MaxLen = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] LenOne = (ADDR_WIDTH + 1)'(1);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic                  loop_q, loop_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic                  inflight_q;

    logic [ADDR_WIDTH:0]   len_clamped;
    logic [CREDIT_W-1:0]   fifo_count;
    logic                  fifo_valid;
    logic                  pop;
    logic                  issue;
    logic                  last;
    logic                  wr_fire;
    logic [CREDIT_W:0]     credit_after;

    assign len_clamped = (i_len > MaxLen) ? MaxLen : i_len;
    assign pop         = fifo_valid && i_smp_ready;
    // Slots committed after this cycle's pop; a new read is allowed only if one stays free.
    assign credit_after = {1'b0, fifo_count} + {{CREDIT_W{1'b0}}, inflight_q}
                        - {{CREDIT_W{1'b0}}, pop};
    assign issue = (state_q == RUN) && (credit_after < (CREDIT_W + 1)'(BUF_DEPTH));
    assign last  = ({1'b0, ptr_q} == (len_q - LenOne));

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        loop_d  = loop_q;
        ptr_d   = ptr_q;
        o_done  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start && (i_len != '0)) begin
                    state_d = RUN;
                    len_d   = len_clamped;
                    loop_d  = i_loop;
                    ptr_d   = '0;
                end
            end
            RUN: begin
                if (issue) begin
                    ptr_d = last ? '0 : ptr_q + ADDR_WIDTH'(1);
                end
                if (i_stop || (issue && last && !loop_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((fifo_count == '0) && !inflight_q) begin
                    state_d = IDLE;
                    o_done  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            loop_q     <= 1'b0;
            ptr_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            ptr_q      <= ptr_d;
            inflight_q <= issue;
        end
    end

    // Gated by reset so every output reads 0 while reset is held.
    assign o_wr_ready    = (state_q == IDLE) && !i_rst;
    assign wr_fire       = i_wr_valid && o_wr_ready;
    assign o_ram_wren    = wr_fire;
    assign o_ram_st_data = wr_fire ? i_wr_data : '0;
    assign o_ram_addr    = issue ? ptr_q : (wr_fire ? i_wr_addr : '0);
    assign o_busy        = (state_q != IDLE);
    assign o_smp_valid   = fifo_valid;

    wave_skid_fifo #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (inflight_q),
        .i_data  (i_ram_ld_data),
        .i_pop   (i_smp_ready),
        .o_valid (fifo_valid),
        .o_data  (o_smp_data),
        .o_count (fifo_count)
    );

endmodule

// File: tb/tb_wave_ram_ctrl.sv
// Directed bench for wave_ram_ctrl with a behavioural single-port RAM and a
// sample scoreboard.
module tb_wave_ram_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned AW = 11;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, stop, loop;
    logic [AW:0]   len;
    logic          wr_valid;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          ram_wren;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_st_data;
    logic [DW-1:0] ram_ld_data;
    logic [DW-1:0] smp_data;
    logic          smp_valid;
    logic          smp_ready;
    logic          busy, done;

    always #5 clk = ~clk;

    wave_ram_ctrl #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start       (start),
        .i_stop        (stop),
        .i_loop        (loop),
        .i_len         (len),
        .i_wr_valid    (wr_valid),
        .i_wr_addr     (wr_addr),
        .i_wr_data     (wr_data),
        .o_wr_ready    (wr_ready),
        .o_ram_wren    (ram_wren),
        .o_ram_addr    (ram_addr),
        .o_ram_st_data (ram_st_data),
        .i_ram_ld_data (ram_ld_data),
        .o_smp_data    (smp_data),
        .o_smp_valid   (smp_valid),
        .i_smp_ready   (smp_ready),
        .o_busy        (busy),
        .o_done        (done)
    );

    // Single-port RAM with registered address: data appears the cycle after.
    logic [DW-1:0] mem [2**AW];
    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_st_data;
        ram_ld_data <= mem[ram_addr];
    end

    int            tests = 0;
    int            fails = 0;
    int            done_cnt = 0;
    int            n_acc = 0;
    int            n0, n_stop, d0;
    logic [DW-1:0] exp_q [$];
    logic          stall_prev = 1'b0;
    logic [DW-1:0] held;
    logic [DW-1:0] pat [4];

    function automatic logic [DW-1:0] ramp(input int a);
        logic [10:0] x;
        x = a[10:0];
        return x[7:0] + {5'b0, x[10:8]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: sample outputs on the falling edge, return 1ns after the rising edge.
    task automatic cycle();
        logic [DW-1:0] e;
        @(negedge clk);
        if (done) done_cnt++;
        if (stall_prev) begin
            chk("hold_valid", {31'b0, smp_valid}, 32'd1);
            chk("hold_data", {24'b0, smp_data}, {24'b0, held});
        end
        if (smp_valid && smp_ready) begin
            if (exp_q.size() == 0) begin
                chk("extra_sample", exp_q.size(), 32'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sample", {24'b0, smp_data}, {24'b0, e});
            end
            n_acc++;
        end
        stall_prev = smp_valid && !smp_ready;
        held       = smp_data;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input string tag, input int max);
        int base;
        base = done_cnt;
        for (int i = 0; i < max && done_cnt == base; i++) cycle();
        chk(tag, done_cnt - base, 32'd1);
    endtask

    initial begin
        pat[0] = 8'h10; pat[1] = 8'h20; pat[2] = 8'h30; pat[3] = 8'h40;
        rst = 1'b1; start = 1'b0; stop = 1'b0; loop = 1'b0; len = '0;
        wr_valid = 1'b0; wr_addr = '0; wr_data = '0; smp_ready = 1'b0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_valid", {31'b0, smp_valid}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_wr_ready", {31'b0, wr_ready}, 32'd0);
        cycle(); cycle();
        rst = 1'b0;
        #1;
        chk("idle_wr_ready", {31'b0, wr_ready}, 32'd1);

        // 1: load four samples, one-shot playback at full rate
        for (int a = 0; a < 4; a++) begin
            wr_valid = 1'b1; wr_addr = a[AW-1:0]; wr_data = pat[a];
            #1;
            chk("wr_wren", {31'b0, ram_wren}, 32'd1);
            cycle();
        end
        wr_valid = 1'b0;
        smp_ready = 1'b1; loop = 1'b0; len = 12'd4;
        for (int i = 0; i < 4; i++) exp_q.push_back(pat[i]);
        start = 1'b1; n0 = n_acc; d0 = done_cnt;
        cycle();
        start = 1'b0;
        chk("lat_e0", {31'b0, smp_valid}, 32'd0);
        cycle();
        chk("lat_e1", {31'b0, smp_valid}, 32'd0);
        cycle();
        chk("lat_e2", {31'b0, smp_valid}, 32'd1);
        repeat (4) cycle();
        chk("t1_burst", n_acc - n0, 32'd4);
        wait_done("t1_done", 10);
        chk("t1_busy", {31'b0, busy}, 32'd0);
        repeat (3) cycle();
        chk("t1_single_done", done_cnt - d0, 32'd1);
        chk("t1_q_empty", exp_q.size(), 32'd0);

        // 2: same window under backpressure
        for (int i = 0; i < 4; i++) exp_q.push_back(pat[i]);
        start = 1'b1; n0 = n_acc;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        smp_ready = 1'b0;
        repeat (5) cycle();
        for (int i = 0; i < 20 && (n_acc - n0) < 4; i++) begin
            smp_ready = ~smp_ready;
            cycle();
        end
        smp_ready = 1'b1;
        wait_done("t2_done", 10);
        chk("t2_count", n_acc - n0, 32'd4);
        chk("t2_q_empty", exp_q.size(), 32'd0);

        // 3: len=3 loop, then stop
        loop = 1'b1; len = 12'd3;
        for (int i = 0; i < 30; i++) exp_q.push_back(pat[i % 3]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            smp_ready = (i % 4 != 3);
            cycle();
        end
        smp_ready = 1'b1; stop = 1'b1;
        cycle();
        stop = 1'b0; n_stop = n_acc;
        chk("t3_busy_drain", {31'b0, busy}, 32'd1);
        wait_done("t3_done", 10);
        chk("t3_stop_tail", {31'b0, (n_acc - n_stop) <= 2}, 32'd1);
        chk("t3_idle", {31'b0, busy}, 32'd0);
        exp_q.delete();

        // 4: len=0 start ignored; start and writes ignored while running
        len = '0; start = 1'b1;
        cycle();
        start = 1'b0;
        chk("t4_len0_idle", {31'b0, busy}, 32'd0);
        smp_ready = 1'b0; loop = 1'b1; len = 12'd4;
        for (int i = 0; i < 12; i++) exp_q.push_back(pat[i % 4]);
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (3) cycle();
        start = 1'b1; len = 12'd2; wr_valid = 1'b1; wr_addr = 11'd1; wr_data = 8'hEE;
        #1;
        chk("t4_wr_ready_run", {31'b0, wr_ready}, 32'd0);
        chk("t4_wren_run", {31'b0, ram_wren}, 32'd0);
        chk("t4_st_data_run", {24'b0, ram_st_data}, 32'd0);
        cycle();
        start = 1'b0; wr_valid = 1'b0; len = 12'd4;
        chk("t4_busy", {31'b0, busy}, 32'd1);
        smp_ready = 1'b1;
        repeat (6) cycle();
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        wait_done("t4_done", 10);
        exp_q.delete();
        loop = 1'b0;
        for (int i = 0; i < 4; i++) exp_q.push_back(pat[i]);
        start = 1'b1; n0 = n_acc;
        cycle();
        start = 1'b0;
        wait_done("t4_replay_done", 20);
        chk("t4_replay_count", n_acc - n0, 32'd4);

        // 5: reset mid-run with the stream stalled
        loop = 1'b1; smp_ready = 1'b0;
        start = 1'b1;
        cycle();
        start = 1'b0;
        repeat (4) cycle();
        chk("t5_pre_valid", {31'b0, smp_valid}, 32'd1);
        d0 = done_cnt;
        rst = 1'b1;
        #1;
        chk("t5_valid", {31'b0, smp_valid}, 32'd0);
        chk("t5_data", {24'b0, smp_data}, 32'd0);
        chk("t5_busy", {31'b0, busy}, 32'd0);
        chk("t5_done", {31'b0, done}, 32'd0);
        chk("t5_wr_ready", {31'b0, wr_ready}, 32'd0);
        chk("t5_addr", {21'b0, ram_addr}, 32'd0);
        stall_prev = 1'b0;
        cycle();
        rst = 1'b0;
        cycle();
        chk("t5_no_done", done_cnt - d0, 32'd0);
        loop = 1'b0; smp_ready = 1'b1;
        for (int i = 0; i < 4; i++) exp_q.push_back(pat[i]);
        start = 1'b1; n0 = n_acc;
        cycle();
        start = 1'b0;
        wait_done("t5_restart_done", 20);
        chk("t5_restart_count", n_acc - n0, 32'd4);

        // 6: full-size window wraps seamlessly; oversize length clamps
        for (int a = 0; a < 2**AW; a++) begin
            wr_valid = 1'b1; wr_addr = a[AW-1:0]; wr_data = ramp(a);
            cycle();
        end
        wr_valid = 1'b0;
        loop = 1'b1; len = 12'h800;
        for (int i = 0; i < 2048 + 40; i++) exp_q.push_back(ramp(i));
        start = 1'b1; n0 = n_acc;
        cycle();
        start = 1'b0;
        for (int i = 0; i < 2200 && (n_acc - n0) < 2068; i++) cycle();
        chk("t6_wrap_count", {31'b0, (n_acc - n0) >= 2068}, 32'd1);
        stop = 1'b1;
        cycle();
        stop = 1'b0;
        wait_done("t6_wrap_done", 10);
        exp_q.delete();
        loop = 1'b0; len = 12'hFFF;
        for (int i = 0; i < 2048; i++) exp_q.push_back(ramp(i));
        start = 1'b1; n0 = n_acc;
        cycle();
        start = 1'b0;
        wait_done("t6_clamp_done", 2100);
        chk("t6_clamp_count", n_acc - n0, 32'd2048);
        chk("t6_q_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
